univ_shift_reg: RTL and testbench

- Parametrised universal shift register for the ShiftRegisters library; successor to the 4-bit serial-in/serial-out block.
- Supports hold, logical shift both directions, rotate both directions, arithmetic shift right, parallel load and clear.
- Includes a shift counter and a word-complete pulse, so it can serialise or deserialise WIDTH-bit words.
- Sits between serial links and parallel datapaths (SISO/SIPO/PISO/PIPO in one block).

---
 rtl/univ_shift_reg.sv | 125 ++++++++++++
 tb/tb_univ_shift_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, logical/arithmetic shift, rotate,
// parallel load and clear, with a word counter and a registered word-complete pulse.
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_ROR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_next_s;
  logic             done_r;
  logic             done_next_s;
  logic             shift_op_s;
  logic             restart_s;

  // Datapath next-state and operation classification.
  always_comb begin
    q_next_s   = q_r;
    shift_op_s = 1'b0;
    restart_s  = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD:  q_next_s = q_r;
        MODE_SHR: begin
          q_next_s   = {sin_r, q_r[WIDTH-1:1]};
          shift_op_s = 1'b1;
        end
        MODE_SHL: begin
          q_next_s   = {q_r[WIDTH-2:0], sin_l};
          shift_op_s = 1'b1;
        end
        MODE_ROR: begin
          q_next_s   = {q_r[0], q_r[WIDTH-1:1]};
          shift_op_s = 1'b1;
        end
        MODE_ROL: begin
          q_next_s   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
          shift_op_s = 1'b1;
        end
        MODE_LOAD: begin
          q_next_s  = pin;
          restart_s = 1'b1;
        end
        MODE_ASR: begin
          q_next_s   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
          shift_op_s = 1'b1;
        end
        MODE_CLEAR: begin
          q_next_s  = {WIDTH{1'b0}};
          restart_s = 1'b1;
        end
        default: q_next_s = q_r;
      endcase
    end else begin
      q_next_s = q_r;
    end
  end

  // Word counter: wraps on the WIDTH-th shift and raises done for one cycle.
  always_comb begin
    cnt_next_s  = cnt_r;
    done_next_s = 1'b0;
    if (shift_op_s) begin
      if (cnt_r == LAST_CNT) begin
        cnt_next_s  = {CW{1'b0}};
        done_next_s = 1'b1;
      end else begin
        cnt_next_s  = cnt_r + CNT_ONE;
        done_next_s = 1'b0;
      end
    end else if (restart_s) begin
      cnt_next_s  = {CW{1'b0}};
      done_next_s = 1'b0;
    end else begin
      cnt_next_s  = cnt_r;
      done_next_s = 1'b0;
    end
  end

  // State registers; reset dominates en and mode and abandons any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= {WIDTH{1'b0}};
      cnt_r  <= {CW{1'b0}};
      done_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      cnt_r  <= cnt_next_s;
      done_r <= done_next_s;
    end
  end

  assign pout   = q_r;
  assign sout_r = q_r[0];
  assign sout_l = q_r[WIDTH-1];
  assign cnt    = cnt_r;
  assign done   = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=4.
module tb_univ_shift_reg;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset;
  logic             en;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] pout;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    cnt;
  logic             done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .pin    (pin),
    .pout   (pout),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .cnt    (cnt),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the current inputs; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic e);
    mode = m;
    en   = e;
    step();
  endtask

  task automatic chk_state(input string tag, input logic [3:0] q_exp,
                           input logic [2:0] cnt_exp, input logic done_exp);
    chk({tag, ".q"},    32'(pout), 32'(q_exp));
    chk({tag, ".cnt"},  32'(cnt),  32'(cnt_exp));
    chk({tag, ".done"}, 32'(done), 32'(done_exp));
  endtask

  initial begin
    logic [3:0] exp_q;
    logic       sr_seq [4];
    logic       sin_seq [4];
    int         pulses;

    reset = 1'b1; en = 1'b1; mode = 3'b101; pin = 4'hF; sin_r = 1'b0; sin_l = 1'b0;
    #2;
    // Reset priority over a pending load.
    step();
    chk_state("reset", 4'b0000, 3'd0, 1'b0);
    reset = 1'b0;

    // Load 1011 then four right shifts with sin_r 0,1,1,0.
    pin = 4'b1011;
    op(3'b101, 1'b1);
    chk_state("load1011", 4'b1011, 3'd0, 1'b0);
    sr_seq  = '{1'b1, 1'b1, 1'b0, 1'b1};
    sin_seq = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("shr_sout_r%0d", i), 32'(sout_r), 32'(sr_seq[i]));
      sin_r = sin_seq[i];
      op(3'b001, 1'b1);
      chk($sformatf("shr_done%0d", i), 32'(done), (i == 3) ? 32'd1 : 32'd0);
    end
    chk_state("shr_final", 4'b0110, 3'd0, 1'b1);
    chk("shr_sout_l", 32'(sout_l), 32'd0);

    // Rotate left a single one around the word.
    pin = 4'b1000;
    op(3'b101, 1'b1);
    chk_state("load1000", 4'b1000, 3'd0, 1'b0);
    chk("rol_sout_l", 32'(sout_l), 32'd1);
    exp_q = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      exp_q = {exp_q[2:0], exp_q[3]};
      op(3'b100, 1'b1);
      chk_state($sformatf("rol%0d", i), exp_q, (i == 3) ? 3'd0 : 3'(i + 1), (i == 3) ? 1'b1 : 1'b0);
    end

    // Arithmetic shift right replicates the sign bit and ignores sin_r.
    pin = 4'b1000; sin_r = 1'b0;
    op(3'b101, 1'b1);
    op(3'b110, 1'b1);
    chk_state("asr0", 4'b1100, 3'd1, 1'b0);
    op(3'b110, 1'b1);
    chk_state("asr1", 4'b1110, 3'd2, 1'b0);

    // Rotate right, then an enabled hold keeps q and cnt.
    pin = 4'b0001;
    op(3'b101, 1'b1);
    op(3'b011, 1'b1);
    chk_state("ror", 4'b1000, 3'd1, 1'b0);
    op(3'b000, 1'b1);
    chk_state("hold", 4'b1000, 3'd1, 1'b0);

    // Two left shifts, three disabled cycles, two more shifts.
    pin = 4'b0001; sin_l = 1'b0;
    op(3'b101, 1'b1);
    op(3'b010, 1'b1);
    op(3'b010, 1'b1);
    chk_state("shl2", 4'b0100, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op(3'b010, 1'b0);
      chk_state($sformatf("en0_%0d", i), 4'b0100, 3'd2, 1'b0);
    end
    op(3'b010, 1'b1);
    chk_state("shl3", 4'b1000, 3'd3, 1'b0);
    op(3'b010, 1'b1);
    chk_state("shl4", 4'b0000, 3'd0, 1'b1);
    op(3'b010, 1'b0);
    chk("en0_done_drop", 32'(done), 32'd0);

    // Twelve back-to-back right shifts: done every fourth cycle, no gap.
    pin = 4'b0000; sin_r = 1'b1;
    op(3'b101, 1'b1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      op(3'b001, 1'b1);
      chk($sformatf("b2b_done%0d", i), 32'(done), (i % 4 == 3) ? 32'd1 : 32'd0);
      if (done === 1'b1) pulses++;
    end
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_q", 32'(pout), 32'hF);

    // Reset after the second shift of a word abandons it.
    op(3'b001, 1'b1);
    op(3'b001, 1'b1);
    chk("pre_reset_cnt", 32'(cnt), 32'd2);
    reset = 1'b1;
    op(3'b001, 1'b1);
    reset = 1'b0;
    chk_state("mid_reset", 4'b0000, 3'd0, 1'b0);
    sin_r = 1'b0;
    op(3'b001, 1'b1);
    op(3'b001, 1'b1);
    chk_state("post_reset2", 4'b0000, 3'd2, 1'b0);

    // Clear after three shifts restarts the word.
    pin = 4'b1111;
    op(3'b101, 1'b1);
    for (int i = 0; i < 3; i++) op(3'b001, 1'b1);
    chk("pre_clear_cnt", 32'(cnt), 32'd3);
    op(3'b111, 1'b1);
    chk_state("clear", 4'b0000, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      op(3'b001, 1'b1);
      chk($sformatf("clr_done%0d", i), 32'(done), (i == 3) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
